fpu_issue_ctrl: RTL and testbench

- Request-side issue stage placed directly upstream of the combinational FP32 add/sub unit (FPU_unit); also captures that unit's result.
- Accepts add/sub requests through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives the head entry onto the FPU operand ports and registers the FPU result and flags into a valid/ready response register.
- Keeps sticky overflow/underflow status bits for software.

---
 rtl/fpu_issue_ctrl.sv | 107 ++++++++++
 tb/tb_fpu_issue_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// Issue stage for the combinational FP32 add/sub unit: request FIFO feeding the FPU operand
// ports, a valid/ready response register capturing its result, and sticky status flags.
module fpu_issue_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_add_sub,
  input  logic [DATA_W-1:0]          i_req_a,
  input  logic [DATA_W-1:0]          i_req_b,
  output logic                       o_fpu_add_sub,
  output logic [DATA_W-1:0]          o_fpu_a,
  output logic [DATA_W-1:0]          o_fpu_b,
  input  logic [DATA_W-1:0]          i_fpu_s,
  input  logic                       i_fpu_ov_flag,
  input  logic                       i_fpu_un_flag,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [DATA_W-1:0]          o_rsp_s,
  output logic                       o_rsp_ov_flag,
  output logic                       o_rsp_un_flag,
  input  logic                       i_flag_clr,
  output logic                       o_sticky_ov,
  output logic                       o_sticky_un,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = 2 * DATA_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     fill;
  logic               empty, push, pop;
  logic [ENTRY_W-1:0] head;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_s_q;
  logic              rsp_ov_q, rsp_un_q;
  logic              sticky_ov_q, sticky_un_q;

  // Extra pointer bit makes the difference span 0..DEPTH without ambiguity.
  assign fill        = wr_ptr_q - rd_ptr_q;
  assign o_count     = CNT_W'(fill);
  assign empty       = (fill == '0);
  assign o_req_ready = (o_count != CNT_W'(DEPTH));
  assign push        = i_req_valid && o_req_ready;
  assign pop         = !empty && (!rsp_valid_q || i_rsp_ready);

  assign head          = mem[rd_ptr_q[PTR_W-1:0]];
  assign o_fpu_add_sub = empty ? 1'b0 : head[ENTRY_W-1];
  assign o_fpu_a       = empty ? '0 : head[2*DATA_W-1:DATA_W];
  assign o_fpu_b       = empty ? '0 : head[DATA_W-1:0];

  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_s       = rsp_s_q;
  assign o_rsp_ov_flag = rsp_ov_q;
  assign o_rsp_un_flag = rsp_un_q;
  assign o_sticky_ov   = sticky_ov_q;
  assign o_sticky_un   = sticky_un_q;

  // Storage is never read while empty, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= {i_req_add_sub, i_req_a, i_req_b};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_s_q     <= '0;
      rsp_ov_q    <= 1'b0;
      rsp_un_q    <= 1'b0;
      sticky_ov_q <= 1'b0;
      sticky_un_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + (PTR_W+1)'(1);
        rsp_valid_q <= 1'b1;
        rsp_s_q     <= i_fpu_s;
        rsp_ov_q    <= i_fpu_ov_flag;
        rsp_un_q    <= i_fpu_un_flag;
      end else if (i_rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      // A flag raised by this cycle's pop survives a simultaneous clear.
      if (i_flag_clr) begin
        sticky_ov_q <= pop && i_fpu_ov_flag;
        sticky_un_q <= pop && i_fpu_un_flag;
      end else begin
        sticky_ov_q <= sticky_ov_q || (pop && i_fpu_ov_flag);
        sticky_un_q <= sticky_un_q || (pop && i_fpu_un_flag);
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl; a lookup-table FPU reference answers the operand ports.
module tb_fpu_issue_ctrl;

  typedef struct packed {
    logic        add_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        ov;
    logic        un;
  } vec_t;

  localparam int NOPS = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_add_sub = 1'b0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        fpu_add_sub;
  logic [31:0] fpu_a, fpu_b, fpu_s;
  logic        fpu_ov, fpu_un;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_s;
  logic        rsp_ov, rsp_un;
  logic        flag_clr = 1'b0;
  logic        sticky_ov, sticky_un;
  logic [2:0]  count;

  vec_t ops [NOPS];
  int   checks = 0;
  int   errors = 0;

  fpu_issue_ctrl #(.DEPTH(4), .DATA_W(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_add_sub (req_add_sub),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .o_fpu_add_sub (fpu_add_sub),
    .o_fpu_a       (fpu_a),
    .o_fpu_b       (fpu_b),
    .i_fpu_s       (fpu_s),
    .i_fpu_ov_flag (fpu_ov),
    .i_fpu_un_flag (fpu_un),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_s       (rsp_s),
    .o_rsp_ov_flag (rsp_ov),
    .o_rsp_un_flag (rsp_un),
    .i_flag_clr    (flag_clr),
    .o_sticky_ov   (sticky_ov),
    .o_sticky_un   (sticky_un),
    .o_count       (count)
  );

  always #5 clk = ~clk;

  // Reference FPU: answers only the operand triples listed in the table.
  always_comb begin
    fpu_s  = '0;
    fpu_ov = 1'b0;
    fpu_un = 1'b0;
    for (int i = 0; i < NOPS; i++) begin
      if (ops[i].add_sub == fpu_add_sub && ops[i].a == fpu_a && ops[i].b == fpu_b) begin
        fpu_s  = ops[i].s;
        fpu_ov = ops[i].ov;
        fpu_un = ops[i].un;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx);
    req_valid   = 1'b1;
    req_add_sub = ops[idx].add_sub;
    req_a       = ops[idx].a;
    req_b       = ops[idx].b;
  endtask

  task automatic idle;
    req_valid   = 1'b0;
    req_add_sub = 1'b0;
    req_a       = '0;
    req_b       = '0;
  endtask

  task automatic pulse_clr;
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
  endtask

  initial begin
    int tx, rx;
    logic rdy;
    logic [31:0] held;

    ops[0] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0}; // 1+2
    ops[1] = '{1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0}; // 3-1
    ops[2] = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0}; // max+max
    ops[3] = '{1'b0, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0}; // 2+2
    ops[4] = '{1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0, 1'b0}; // 1-2
    ops[5] = '{1'b0, 32'h3F000000, 32'h3F000000, 32'h3F800000, 1'b0, 1'b0}; // .5+.5
    ops[6] = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0}; // 1+1
    ops[7] = '{1'b1, 32'h40800000, 32'h3F800000, 32'h40400000, 1'b0, 1'b0}; // 4-1
    ops[8] = '{1'b1, 32'h00800001, 32'h00800000, 32'h00000000, 1'b0, 1'b1}; // tiny diff

    step();
    step();
    rst = 1'b0;
    chk("reset_count", 32'(count), 0);
    chk("reset_req_ready", 32'(req_ready), 1);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_s", rsp_s, 0);
    chk("reset_rsp_flags", {30'd0, rsp_ov, rsp_un}, 0);
    chk("reset_sticky", {30'd0, sticky_ov, sticky_un}, 0);
    chk("reset_fpu_a", fpu_a, 0);

    // Single requests: 2-edge latency, head presented to the FPU, flags captured.
    rsp_ready = 1'b1;
    for (int i = 0; i < NOPS; i++) begin
      drive(i);
      step();
      idle();
      chk("vec_count_after_push", 32'(count), 1);
      chk("vec_rsp_not_yet", 32'(rsp_valid), 0);
      chk("vec_fpu_a", fpu_a, ops[i].a);
      chk("vec_fpu_b", fpu_b, ops[i].b);
      step();
      chk("vec_rsp_valid", 32'(rsp_valid), 1);
      chk("vec_rsp_s", rsp_s, ops[i].s);
      chk("vec_rsp_flags", {30'd0, rsp_ov, rsp_un}, {30'd0, ops[i].ov, ops[i].un});
      chk("vec_sticky_ov", 32'(sticky_ov), 32'(i >= 2));
      chk("vec_sticky_un", 32'(sticky_un), 32'(i >= 8));
      chk("vec_count_after_pop", 32'(count), 0);
    end
    step();
    chk("vec_rsp_drained", 32'(rsp_valid), 0);
    pulse_clr();
    chk("clr_after_vec", {30'd0, sticky_ov, sticky_un}, 0);

    // Back-to-back: one response per cycle, in order, occupancy never above 1.
    tx = 0;
    rx = 0;
    drive(0);
    for (int c = 0; c < 12; c++) begin
      step();
      if (tx < 8) tx++;
      if (tx < 8) drive(tx);
      else idle();
      chk("b2b_rsp_valid_cadence", 32'(rsp_valid), 32'(c >= 1 && c <= 8));
      if (rsp_valid) begin
        chk("b2b_rsp_s", rsp_s, ops[rx].s);
        rx++;
      end
      if (count > 3'd1) chk("b2b_count_le1", 32'(count), 1);
    end
    chk("b2b_total", rx, 8);
    pulse_clr();

    // Backpressure: 6 offered, 5 absorbed (4 FIFO + 1 response register).
    rsp_ready = 1'b0;
    tx = 0;
    for (int c = 0; c < 8; c++) begin
      if (tx < 6) drive(tx);
      else idle();
      rdy = req_ready;
      step();
      if (rdy && tx < 6) tx++;
    end
    chk("bp_accepted", tx, 5);
    chk("bp_req_ready", 32'(req_ready), 0);
    chk("bp_count", 32'(count), 4);
    chk("bp_rsp_valid", 32'(rsp_valid), 1);
    chk("bp_rsp_s", rsp_s, ops[0].s);
    held = rsp_s;
    idle();
    step();
    chk("bp_rsp_s_stable", rsp_s, held);
    chk("bp_count_stable", 32'(count), 4);
    rsp_ready = 1'b1;
    rx = 0;
    for (int g = 0; g < 20 && rx < 5; g++) begin
      if (rsp_valid) begin
        chk("bp_drain_s", rsp_s, ops[rx].s);
        rx++;
      end
      step();
    end
    chk("bp_drain_total", rx, 5);
    chk("bp_drain_count", 32'(count), 0);
    chk("bp_drain_rsp_valid", 32'(rsp_valid), 0);
    pulse_clr();

    // Overflow sticks through clean results until cleared.
    drive(2);
    step();
    idle();
    step();
    chk("ov_rsp_flag", 32'(rsp_ov), 1);
    chk("ov_sticky_set", 32'(sticky_ov), 1);
    drive(0);
    step();
    idle();
    step();
    chk("ov_clean_rsp_flag", 32'(rsp_ov), 0);
    chk("ov_sticky_held", 32'(sticky_ov), 1);
    pulse_clr();
    chk("ov_sticky_cleared", 32'(sticky_ov), 0);

    // Clear collides with an overflowing pop: the set wins.
    drive(2);
    step();
    idle();
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("collide_rsp_ov", 32'(rsp_ov), 1);
    chk("collide_sticky_ov", 32'(sticky_ov), 1);
    pulse_clr();
    chk("collide_clear_idle", 32'(sticky_ov), 0);

    // Reset with 3 queued and a response pending.
    rsp_ready = 1'b0;
    drive(2);
    step();
    drive(0);
    step();
    drive(1);
    step();
    drive(3);
    step();
    idle();
    chk("prerst_count", 32'(count), 3);
    chk("prerst_rsp_valid", 32'(rsp_valid), 1);
    chk("prerst_sticky_ov", 32'(sticky_ov), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_s", rsp_s, 0);
    chk("rst_sticky", {30'd0, sticky_ov, sticky_un}, 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_fpu_ops", fpu_a | fpu_b | 32'(fpu_add_sub), 0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rst_no_stale_rsp", 32'(rsp_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
